// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests, a prefetch FIFO
// and redirect handling that flushes the FIFO and discards in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [OW-1:0] out_cnt, out_nx, disc_cnt, disc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] fetch_pc, fetch_nx, rsp_pc, tgt;
  logic stale, fire, hold, push, pop, raise;
  logic [31:0] data_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  assign instr_valid_o = cnt != '0;
  assign instr_o = instr_valid_o ? data_q[rd_ptr] : '0;
  assign instr_pc_o = instr_valid_o ? pc_q[rd_ptr] : '0;
  always_comb begin
    tgt = redirect_pc_i & ~32'd3;
    fire = imem_req_valid_o & imem_req_ready_i;
    hold = imem_req_valid_o & ~imem_req_ready_i;
    pop = instr_valid_o & instr_ready_i & ~redirect_i;
    push = imem_rsp_valid_i & (disc_cnt == '0) & ~redirect_i;
    out_nx = out_cnt + OW'(fire) - OW'(imem_rsp_valid_i);
    cnt_nx = redirect_i ? '0 : cnt + CW'(push) - CW'(pop);
    disc_nx = redirect_i ? out_nx
            : disc_cnt - OW'(imem_rsp_valid_i && disc_cnt != '0) + OW'(fire & stale);
    // A stale request already consumed its address slot; the redirect target is still next.
    fetch_nx = redirect_i ? tgt : (fire & ~stale) ? fetch_pc + 32'd4 : fetch_pc;
    raise = ~redirect_i && (out_nx < OW'(MAX_OUTSTANDING))
         && ((CW+1)'(out_nx) + (CW+1)'(cnt_nx) < (CW+1)'(DEPTH));
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      imem_req_valid_o <= 1'b0;
      imem_req_addr_o <= RESET_PC;
      out_cnt <= '0;
      disc_cnt <= '0;
      cnt <= '0;
      stale <= 1'b0;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (!hold) begin
        imem_req_valid_o <= raise;
        imem_req_addr_o <= fetch_nx;
      end
      out_cnt <= out_nx;
      disc_cnt <= disc_nx;
      cnt <= cnt_nx;
      stale <= redirect_i ? hold : stale & ~fire;
      fetch_pc <= fetch_nx;
      rsp_pc <= redirect_i ? tgt : push ? rsp_pc + 32'd4 : rsp_pc;
      wr_ptr <= redirect_i ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect_i ? '0 : rd_ptr + AW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rsp_data_i;
      pc_q[wr_ptr] <= rsp_pc;
    end
  end
  assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && !pop && cnt == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a one-cycle-latency instruction memory model.
module tb_fetch_unit;
  logic clk_i = 1'b0, rstn_i = 1'b0;
  logic req_valid, req_ready = 1'b0, rsp_valid = 1'b0, redirect = 1'b0;
  logic instr_valid, instr_ready = 1'b0;
  logic [31:0] req_addr, rsp_data = '0, redirect_pc = '0, instr, instr_pc;
  logic [31:0] reqs[$], fired[$], gpc[$], gin[$];
  bit mem_on = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  fetch_unit dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc)
  );
  function automatic logic [31:0] mdata(logic [31:0] a);
    return ~a ^ 32'h1234_0000;
  endfunction
  function automatic logic [31:0] fired_at(int i);
    return i < fired.size() ? fired[i] : 32'hxxxx_xxxx;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  // Memory answers each accepted request on the following cycle while mem_on is set.
  task automatic tick();
    if (req_valid && req_ready) begin
      reqs.push_back(req_addr);
      fired.push_back(req_addr);
    end
    if (instr_valid && instr_ready && !redirect) begin
      gpc.push_back(instr_pc);
      gin.push_back(instr);
    end
    @(posedge clk_i);
    #1;
    redirect = 1'b0;
    if (mem_on && reqs.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data = mdata(reqs.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data = '0;
    end
  endtask
  task automatic wait_valid(string tag, int n);
    for (int i = 0; i < n && !instr_valid; i++) tick();
    chk1({tag, "_valid"}, instr_valid, 1'b1);
  endtask
  initial begin
    int n;
    logic [31:0] held;
    tick();
    tick();
    chk1("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    // Streaming from reset
    rstn_i = 1'b1; req_ready = 1'b1; instr_ready = 1'b1; mem_on = 1'b1;
    tick();
    chk1("t1_req_valid", req_valid, 1'b1);
    chk("t1_addr0", req_addr, 32'h0);
    tick();
    chk("t1_addr1", req_addr, 32'h4);
    chk1("t1_not_yet", instr_valid, 1'b0);
    tick();
    chk1("t1_valid3", instr_valid, 1'b1);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_instr0", instr, mdata(32'h0));
    repeat (8) tick();
    chk("t1_pops", 32'(gpc.size()), 32'd8);
    // Decode stall fills the FIFO, then drains in order
    instr_ready = 1'b0;
    repeat (10) tick();
    chk1("t2_req_idle", req_valid, 1'b0);
    chk1("t2_head_valid", instr_valid, 1'b1);
    chk("t2_head_pc", instr_pc, 32'd32);
    chk("t2_fired", 32'(fired.size()), 32'd12);
    instr_ready = 1'b1;
    repeat (12) tick();
    chk("t2_pops", 32'(gpc.size()), 32'd20);
    for (int i = 0; i < gpc.size(); i++) begin
      chk("t12_pc", gpc[i], 32'(4 * i));
      chk("t12_word", gin[i], mdata(32'(4 * i)));
    end
    // Redirect with two responses outstanding
    mem_on = 1'b0;
    repeat (4) tick();
    chk1("t3_req_idle", req_valid, 1'b0);
    chk1("t3_empty", instr_valid, 1'b0);
    chk("t3_pending", 32'(reqs.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100; mem_on = 1'b1;
    tick();
    chk1("t3_flush", instr_valid, 1'b0);
    n = fired.size();
    wait_valid("t3", 20);
    chk("t3_pc", instr_pc, 32'h100);
    chk("t3_word", instr, mdata(32'h100));
    chk("t3_first_fire", fired_at(n), 32'h100);
    // Redirect while a request is stalled by the memory
    req_ready = 1'b0;
    for (int i = 0; i < 10 && !req_valid; i++) tick();
    chk1("t4_req_pending", req_valid, 1'b1);
    held = req_addr;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk1("t4_hold_valid", req_valid, 1'b1);
    chk("t4_hold_addr", req_addr, held);
    tick();
    tick();
    chk("t4_hold_addr2", req_addr, held);
    n = fired.size();
    req_ready = 1'b1;
    wait_valid("t4", 20);
    chk("t4_pc", instr_pc, 32'h200);
    chk("t4_word", instr, mdata(32'h200));
    chk("t4_fire_old", fired_at(n), held);
    chk("t4_fire_new", fired_at(n + 1), 32'h200);
    // Unaligned redirect colliding with a pop and a response
    repeat (3) tick();
    chk1("t5_pre_valid", instr_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    chk1("t5_flush", instr_valid, 1'b0);
    n = fired.size();
    wait_valid("t5", 20);
    chk("t5_pc", instr_pc, 32'h200);
    chk("t5_word", instr, mdata(32'h200));
    chk("t5_first_fire", fired_at(n), 32'h200);
    // Asynchronous reset mid-stream
    instr_ready = 1'b0;
    repeat (3) tick();
    chk1("t6_pre_valid", instr_valid, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    chk1("t6_req_valid", req_valid, 1'b0);
    chk("t6_req_addr", req_addr, 32'h0);
    chk1("t6_instr_valid", instr_valid, 1'b0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_instr_pc", instr_pc, 32'h0);
    reqs.delete();
    rsp_valid = 1'b0; rsp_data = '0;
    tick();
    rstn_i = 1'b1; instr_ready = 1'b1;
    n = fired.size();
    wait_valid("t6", 10);
    chk("t6_pc", instr_pc, 32'h0);
    chk("t6_word", instr, mdata(32'h0));
    chk("t6_first_fire", fired_at(n), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
